unidad_writeback_rf: RTL and testbench
======================================

# unidad_writeback_rf

Writeback controller sitting in front of the 32x32 register file: the producer side of its write port. It collects results from the single-cycle ALU path and the multi-cycle load path and arbitrates between them. It drives exactly one registered write per cycle into the register file's write_addr/write_data and suppresses writes to x0. It also keeps a busy scoreboard for outstanding loads so the decode stage can stall on read-after-write hazards against the register file's two read addresses.

## Interface
- LD_DEPTH, 2, load-result buffer depth in entries (power of two, >= 2)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- alu_valid  in  1  ALU result present this cycle (no backpressure)
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- ld_valid  in  1  load result offered
- ld_ready  out  1  load result accepted when ld_valid && ld_ready
- ld_rd  in  5  load destination register
- ld_data  in  32  load data
- ld_issue  in  1  a load to ld_issue_rd was issued this cycle
- ld_issue_rd  in  5  destination of issued load
- addr1, addr2  in  5 each  decode-stage source registers (same values driven to register-file read ports)
- hazard1, hazard2  out  1 each  source register has an outstanding load
- write_en  out  1  register-file write strobe
- write_addr  out  5  register-file write address
- write_data  out  32  register-file write data
- fwd1_hit, fwd2_hit  out  1 each  write stage holds value for addr1/addr2 (BYPASS_EN only)
- fwd1_data, fwd2_data  out  32 each  forwarded value (BYPASS_EN only)

## Operation
- Load buffer: FIFO of LD_DEPTH {rd, data} entries, pointers wrap modulo LD_DEPTH, count 0..LD_DEPTH.
- ld_ready = (count < LD_DEPTH), from count only; a pop in the same cycle does not open a slot.
- Accepted load with ld_rd = 0: handshake completes, nothing enqueued.
- Arbitration per cycle, into the write stage register:
  - alu_valid && alu_rd != 0: ALU wins; FIFO head stays.
  - Otherwise, FIFO non-empty: pop head.
  - Otherwise: write_en <= 0; write_addr/write_data hold their previous values.
- alu_valid with alu_rd = 0 is discarded and does not block a FIFO pop that cycle.
- Scoreboard busy[31:0], busy[0] hard-wired 0:
  - ld_issue && ld_issue_rd != 0 sets busy[ld_issue_rd].
  - A FIFO pop clears busy[popped rd].
  - Set and clear of the same register in the same cycle: set wins.
- hazard1 = busy[addr1], hazard2 = busy[addr2], combinational.
- An ALU write to a busy register is performed and leaves busy unchanged.
- Simultaneous FIFO push and pop with count < LD_DEPTH: count unchanged, both take effect.

## Timing
- Reset (rst low, async): write_en=0, write_addr=0, write_data=0, FIFO empty (count=0), busy=0, fwd*_hit=0, fwd*_data=0. ld_ready=1 while in reset and after release.
- Reset mid-operation discards buffered loads and all busy bits, and cancels any pending write.
- ALU latency: result in cycle n gives write_en=1 with its rd/data in cycle n+1.
- Load latency: accepted in cycle n into an empty FIFO with no competing ALU write gives write in n+2.
- Each competing ALU cycle adds one cycle of delay to the FIFO head.
- hazard clears in the cycle after the pop, i.e. concurrently with write_en for that load. The register file then holds the new value from n+1 onward.

## Configuration
- WB_BYPASS_EN defined:
  - fwdK_hit = write_en && write_addr == addrK && addrK != 0.
  - fwdK_data = write_data when hit, else 0.
  - hazardK is additionally masked by fwdK_hit in the cycle the load is written.
- WB_BYPASS_EN undefined: fwd*_hit and fwd*_data tied to 0; hazards as defined above.

## Test plan
- Reset, then alu_valid, rd=1, data=32'hDEADBEEF -> next cycle write_en=1, write_addr=1, write_data=32'hDEADBEEF; following cycle write_en=0.
- alu_valid, rd=0, data=32'h12345678 -> write_en stays 0. Load (rd=3, 32'hCAFEBABE) buffered same cycle -> written next cycle.
- Two loads (rd=4, 5) accepted back-to-back while ALU writes rd=6,7,8 continuously -> ld_ready=0 after second accept. Writes in order 6,7,8,4,5; ld_ready returns to 1 the cycle after the first pop.
- ld_issue rd=2, addr1=2 -> hazard1=1 until load rd=2 (32'h0000ABCD) is popped. hazard1=0 in the write cycle; with WB_BYPASS_EN, fwd1_hit=1, fwd1_data=32'h0000ABCD.
- ld_issue rd=9 in the same cycle a load rd=9 pops -> busy[9] remains 1, hazard2=1 for addr2=9.
- rst low while FIFO holds 2 entries and busy[4]=1 -> immediately write_en=0, busy=0, ld_ready=1. No buffered write appears after release.

Source files
------------

// File: rtl/unidad_writeback_rf_if.sv
// Writeback bus bundle: ALU result, load-result handshake, load-issue notification,
// decode-stage source addresses with hazard/forward feedback, and the register-file
// write port.
//   master : the pipeline side (drives results, issue info and read addresses)
//   slave  : the writeback controller
interface unidad_writeback_rf_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic [4:0]  addr1;
  logic [4:0]  addr2;
  logic        hazard1;
  logic        hazard2;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        fwd1_hit;
  logic        fwd2_hit;
  logic [31:0] fwd1_data;
  logic [31:0] fwd2_data;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, ld_issue, ld_issue_rd,
           addr1, addr2,
    input  ld_ready, hazard1, hazard2, write_en, write_addr, write_data,
           fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, ld_issue, ld_issue_rd,
           addr1, addr2,
    output ld_ready, hazard1, hazard2, write_en, write_addr, write_data,
           fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
  );
endinterface

// File: rtl/unidad_writeback_rf.sv
// Writeback controller in front of the 32x32 register file write port.
// Arbitrates between the single-cycle ALU result (always wins) and a FIFO of
// buffered load results, registers exactly one write per cycle, drops writes to x0
// and keeps a busy scoreboard of outstanding loads for decode-stage RAW stalls.
// Ports:
//   clk_i  - clock, rising edge
//   rst_ni - asynchronous active-low reset
//   wb     - writeback bundle (slave modport)
// Optional feature: define WB_BYPASS_EN to forward the write-stage value to the
// decode stage (fwd*_hit/fwd*_data) and mask the hazard of a load being written.
module unidad_writeback_rf #(
  parameter int unsigned LD_DEPTH = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  unidad_writeback_rf_if.slave    wb
);

  localparam int unsigned PtrW = $clog2(LD_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [4:0]      fifo_rd_q   [LD_DEPTH];
  logic [31:0]     fifo_data_q [LD_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     busy_q, busy_d;
  logic            we_q, we_d;
  logic [4:0]      addr_q, addr_d;
  logic [31:0]     data_q, data_d;

  logic       ld_ready;
  logic       alu_win;
  logic       push;
  logic       pop;
  logic [4:0] head_rd;

  // Ready depends on occupancy only; a concurrent pop never opens a slot.
  assign ld_ready = (count_q < CntW'(LD_DEPTH));
  assign alu_win  = wb.alu_valid && (wb.alu_rd != 5'd0);
  // Loads to x0 complete the handshake but are never buffered.
  assign push     = wb.ld_valid && ld_ready && (wb.ld_rd != 5'd0);
  assign pop      = !alu_win && (count_q != '0);
  assign head_rd  = fifo_rd_q[rd_ptr_q];

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    count_d = count_q + CntW'(push) - CntW'(pop);
  end

  // Write stage: address/data hold when nothing is written.
  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (alu_win) begin
      we_d   = 1'b1;
      addr_d = wb.alu_rd;
      data_d = wb.alu_data;
    end else if (pop) begin
      we_d   = 1'b1;
      addr_d = head_rd;
      data_d = fifo_data_q[rd_ptr_q];
    end
  end

  // Clear on pop first so a same-cycle issue to the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (pop) busy_d[head_rd] = 1'b0;
    if (wb.ld_issue && (wb.ld_issue_rd != 5'd0)) busy_d[wb.ld_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  // Storage needs no reset: entries are only read when count says they are valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= wb.ld_rd;
      fifo_data_q[wr_ptr_q] <= wb.ld_data;
    end
  end

  assign wb.ld_ready   = ld_ready;
  assign wb.write_en   = we_q;
  assign wb.write_addr = addr_q;
  assign wb.write_data = data_q;

`ifdef WB_BYPASS_EN
  // Marks a write-stage entry that came from the load FIFO.
  logic wb_ld_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) wb_ld_q <= 1'b0;
    else         wb_ld_q <= pop;
  end

  logic fwd1_hit, fwd2_hit;
  assign fwd1_hit     = we_q && (addr_q == wb.addr1) && (wb.addr1 != 5'd0);
  assign fwd2_hit     = we_q && (addr_q == wb.addr2) && (wb.addr2 != 5'd0);
  assign wb.fwd1_hit  = fwd1_hit;
  assign wb.fwd2_hit  = fwd2_hit;
  assign wb.fwd1_data = fwd1_hit ? data_q : 32'd0;
  assign wb.fwd2_data = fwd2_hit ? data_q : 32'd0;
  assign wb.hazard1   = busy_q[wb.addr1] && !(fwd1_hit && wb_ld_q);
  assign wb.hazard2   = busy_q[wb.addr2] && !(fwd2_hit && wb_ld_q);
`else
  assign wb.fwd1_hit  = 1'b0;
  assign wb.fwd2_hit  = 1'b0;
  assign wb.fwd1_data = 32'd0;
  assign wb.fwd2_data = 32'd0;
  assign wb.hazard1   = busy_q[wb.addr1];
  assign wb.hazard2   = busy_q[wb.addr2];
`endif

endmodule

// File: tb/tb_unidad_writeback_rf.sv
// Bench for unidad_writeback_rf: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based reference model.
module tb_unidad_writeback_rf;

  localparam int unsigned LdDepth = 2;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  unidad_writeback_rf_if wb_if ();

  unidad_writeback_rf #(
    .LD_DEPTH(LdDepth)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .wb     (wb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  // Reference model state
  ent_t        m_q[$];
  bit   [31:0] m_busy;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_from_ld;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_busy    = '0;
    m_we      = 1'b0;
    m_addr    = '0;
    m_data    = '0;
    m_from_ld = 1'b0;
  endtask

  function automatic bit m_fwd_hit(input logic [4:0] a);
`ifdef WB_BYPASS_EN
    return m_we && (m_addr == a) && (a != 5'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_hazard(input logic [4:0] a);
    return m_busy[a] && !(m_fwd_hit(a) && m_from_ld);
  endfunction

  task automatic check_model();
    chk("ld_ready", 32'(wb_if.ld_ready), 32'(m_q.size() < LdDepth));
    chk("write_en", 32'(wb_if.write_en), 32'(m_we));
    chk("write_addr", 32'(wb_if.write_addr), 32'(m_addr));
    chk("write_data", wb_if.write_data, m_data);
    chk("hazard1", 32'(wb_if.hazard1), 32'(m_hazard(wb_if.addr1)));
    chk("hazard2", 32'(wb_if.hazard2), 32'(m_hazard(wb_if.addr2)));
    chk("fwd1_hit", 32'(wb_if.fwd1_hit), 32'(m_fwd_hit(wb_if.addr1)));
    chk("fwd2_hit", 32'(wb_if.fwd2_hit), 32'(m_fwd_hit(wb_if.addr2)));
    chk("fwd1_data", wb_if.fwd1_data, m_fwd_hit(wb_if.addr1) ? m_data : 32'd0);
    chk("fwd2_data", wb_if.fwd2_data, m_fwd_hit(wb_if.addr2) ? m_data : 32'd0);
  endtask

  // One clock of the specification's rules, applied to the current inputs.
  task automatic model_advance();
    bit   ready;
    ent_t e;
    ready = (m_q.size() < LdDepth);
    if (wb_if.alu_valid && wb_if.alu_rd != 5'd0) begin
      m_we = 1'b1; m_addr = wb_if.alu_rd; m_data = wb_if.alu_data; m_from_ld = 1'b0;
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      m_we = 1'b1; m_addr = e.rd; m_data = e.data; m_from_ld = 1'b1;
      m_busy[e.rd] = 1'b0;
    end else begin
      m_we = 1'b0; m_from_ld = 1'b0;
    end
    if (wb_if.ld_valid && ready && wb_if.ld_rd != 5'd0) begin
      e.rd = wb_if.ld_rd; e.data = wb_if.ld_data;
      m_q.push_back(e);
    end
    if (wb_if.ld_issue && wb_if.ld_issue_rd != 5'd0) m_busy[wb_if.ld_issue_rd] = 1'b1;
  endtask

  // Inputs are set by the caller at posedge+2; compare at negedge+1.
  task automatic step();
    @(negedge clk);
    #1;
    check_model();
    model_advance();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    wb_if.alu_valid   = 1'b0; wb_if.alu_rd = '0; wb_if.alu_data = '0;
    wb_if.ld_valid    = 1'b0; wb_if.ld_rd  = '0; wb_if.ld_data  = '0;
    wb_if.ld_issue    = 1'b0; wb_if.ld_issue_rd = '0;
    wb_if.addr1       = '0;   wb_if.addr2  = '0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    wb_if.alu_valid = 1'b1; wb_if.alu_rd = rd; wb_if.alu_data = d;
  endtask

  task automatic ld(input logic [4:0] rd, input logic [31:0] d);
    wb_if.ld_valid = 1'b1; wb_if.ld_rd = rd; wb_if.ld_data = d;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("rst write_en", 32'(wb_if.write_en), 32'd0);
    chk("rst write_addr", 32'(wb_if.write_addr), 32'd0);
    chk("rst write_data", wb_if.write_data, 32'd0);
    chk("rst ld_ready", 32'(wb_if.ld_ready), 32'd1);
    chk("rst fwd1_hit", 32'(wb_if.fwd1_hit), 32'd0);
    rst_n = 1'b1;
    chk("post-rst ld_ready", 32'(wb_if.ld_ready), 32'd1);

    // ALU latency and single-cycle strobe
    alu(5'd1, 32'hDEADBEEF);
    step();
    chk("alu we", 32'(wb_if.write_en), 32'd1);
    chk("alu addr", 32'(wb_if.write_addr), 32'd1);
    chk("alu data", wb_if.write_data, 32'hDEADBEEF);
    idle();
    step();
    chk("alu we drop", 32'(wb_if.write_en), 32'd0);
    chk("alu data hold", wb_if.write_data, 32'hDEADBEEF);

    // ALU to x0 discarded; load buffered the same cycle is written next cycle
    alu(5'd0, 32'h12345678);
    ld(5'd3, 32'hCAFEBABE);
    step();
    chk("x0 we", 32'(wb_if.write_en), 32'd0);
    idle();
    step();
    chk("ld3 we", 32'(wb_if.write_en), 32'd1);
    chk("ld3 addr", 32'(wb_if.write_addr), 32'd3);
    chk("ld3 data", wb_if.write_data, 32'hCAFEBABE);

    // Two loads held off by three ALU writes
    idle(); alu(5'd6, 32'h66); ld(5'd4, 32'h44);
    step();
    chk("c0 addr", 32'(wb_if.write_addr), 32'd6);
    chk("c0 ready", 32'(wb_if.ld_ready), 32'd1);
    idle(); alu(5'd7, 32'h77); ld(5'd5, 32'h55);
    step();
    chk("c1 addr", 32'(wb_if.write_addr), 32'd7);
    chk("c1 ready", 32'(wb_if.ld_ready), 32'd0);
    idle(); alu(5'd8, 32'h88);
    step();
    chk("c2 addr", 32'(wb_if.write_addr), 32'd8);
    chk("c2 ready", 32'(wb_if.ld_ready), 32'd0);
    idle();
    step();
    chk("c3 addr", 32'(wb_if.write_addr), 32'd4);
    chk("c3 data", wb_if.write_data, 32'h44);
    chk("c3 ready", 32'(wb_if.ld_ready), 32'd1);
    step();
    chk("c4 addr", 32'(wb_if.write_addr), 32'd5);
    chk("c4 we", 32'(wb_if.write_en), 32'd1);
    step();
    chk("c5 we", 32'(wb_if.write_en), 32'd0);

    // Hazard on an outstanding load, cleared in its write cycle
    idle(); wb_if.ld_issue = 1'b1; wb_if.ld_issue_rd = 5'd2; wb_if.addr1 = 5'd2;
    step();
    chk("d0 hazard1", 32'(wb_if.hazard1), 32'd1);
    idle(); wb_if.addr1 = 5'd2; ld(5'd2, 32'h0000ABCD);
    step();
    chk("d1 hazard1", 32'(wb_if.hazard1), 32'd1);
    idle(); wb_if.addr1 = 5'd2;
    step();
    chk("d2 hazard1", 32'(wb_if.hazard1), 32'd0);
    chk("d2 addr", 32'(wb_if.write_addr), 32'd2);
`ifdef WB_BYPASS_EN
    chk("d2 fwd1_hit", 32'(wb_if.fwd1_hit), 32'd1);
    chk("d2 fwd1_data", wb_if.fwd1_data, 32'h0000ABCD);
`else
    chk("d2 fwd1_hit", 32'(wb_if.fwd1_hit), 32'd0);
    chk("d2 fwd1_data", wb_if.fwd1_data, 32'd0);
`endif

    // Issue and pop of the same register in one cycle: set wins
    idle(); ld(5'd9, 32'h99);
    step();
    idle(); wb_if.ld_issue = 1'b1; wb_if.ld_issue_rd = 5'd9; wb_if.addr2 = 5'd9;
    step();
    chk("e addr", 32'(wb_if.write_addr), 32'd9);
`ifdef WB_BYPASS_EN
    chk("e hazard2", 32'(wb_if.hazard2), 32'd0);
`else
    chk("e hazard2", 32'(wb_if.hazard2), 32'd1);
`endif
    idle(); wb_if.addr2 = 5'd9;
    step();
    chk("e busy kept", 32'(wb_if.hazard2), 32'd1);

    // Reset mid-operation with two buffered loads and busy[4]
    idle(); alu(5'd10, 32'hA); ld(5'd11, 32'hB); wb_if.ld_issue = 1'b1; wb_if.ld_issue_rd = 5'd4;
    step();
    idle(); alu(5'd12, 32'hC); ld(5'd13, 32'hD);
    step();
    idle(); wb_if.addr1 = 5'd4;
    @(negedge clk);
    #1;
    chk("f pre hazard1", 32'(wb_if.hazard1), 32'd1);
    chk("f pre ready", 32'(wb_if.ld_ready), 32'd0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("f we", 32'(wb_if.write_en), 32'd0);
    chk("f ready", 32'(wb_if.ld_ready), 32'd1);
    chk("f hazard1", 32'(wb_if.hazard1), 32'd0);
    check_model();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("f post we", 32'(wb_if.write_en), 32'd0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      wb_if.alu_valid   = ($urandom_range(0, 99) < 45);
      wb_if.alu_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      wb_if.alu_data    = $urandom;
      wb_if.ld_valid    = ($urandom_range(0, 99) < 50);
      wb_if.ld_rd       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      wb_if.ld_data     = $urandom;
      wb_if.ld_issue    = ($urandom_range(0, 99) < 30);
      wb_if.ld_issue_rd = 5'($urandom);
      wb_if.addr1       = 5'($urandom);
      wb_if.addr2       = ($urandom_range(0, 3) == 0) ? wb_if.write_addr : 5'($urandom);
      step();
    end
    @(negedge clk);
    #1;
    check_model();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
